// File: rtl/nibble_result_unloader.sv
// Captures in_a*in_b as a 16-bit product on a start request.
// Streams the product out as four nibbles using a valid/ack handshake.
// Aborts with a timeout pulse if the receiver stalls for too long.
module nibble_result_unloader #(
  parameter int unsigned MSB_FIRST   = 0,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  output logic [3:0] nib_out,
  output logic       nib_valid,
  output logic [1:0] nib_idx,
  input  logic       nib_ack,
  output logic       busy,
  output logic       done,
  output logic       timeout
);

  // Stall counter only needs to reach ACK_TIMEOUT; one bit minimum.
  localparam int unsigned STALL_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [STALL_W:0] STALL_LIMIT = (STALL_W + 1)'(ACK_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [15:0]        product, product_n;
  logic [1:0]         cnt, cnt_n;
  logic [STALL_W-1:0] stall, stall_n;
  logic [STALL_W:0]   stall_inc;

  logic [3:0] nib_out_n;
  logic [1:0] nib_idx_n;
  logic       nib_valid_n;
  logic       busy_n;
  logic       done_n;
  logic       timeout_n;

  // Map the transfer count to the physical nibble position.
  function automatic logic [1:0] phys_idx(input logic [1:0] c);
    return (MSB_FIRST != 0) ? ~c : c;
  endfunction

  assign stall_inc = {1'b0, stall} + {{STALL_W{1'b0}}, 1'b1};

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      product   <= '0;
      cnt       <= '0;
      stall     <= '0;
      nib_out   <= '0;
      nib_idx   <= '0;
      nib_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      product   <= product_n;
      cnt       <= cnt_n;
      stall     <= stall_n;
      nib_out   <= nib_out_n;
      nib_idx   <= nib_idx_n;
      nib_valid <= nib_valid_n;
      busy      <= busy_n;
      done      <= done_n;
      timeout   <= timeout_n;
    end
  end

  // Next-state logic, plus output values decoded from the next state.
  // Decoding from the next state keeps every output registered while
  // still showing the first nibble in the cycle right after start.
  always_comb begin
    state_n   = state;
    product_n = product;
    cnt_n     = cnt;
    stall_n   = stall;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_n   = SEND;
          product_n = 16'(in_a) * 16'(in_b);
          cnt_n     = '0;
          stall_n   = '0;
        end
      end
      SEND: begin
        if (nib_ack) begin
          stall_n = '0;
          if (cnt == 2'd3) begin
            state_n = DONE;
          end else begin
            cnt_n = cnt + 2'd1;
          end
        end else if (ACK_TIMEOUT != 0) begin
          if (stall_inc == STALL_LIMIT) begin
            state_n = ERR;
          end else begin
            stall_n = stall_inc[STALL_W-1:0];
          end
        end
      end
      DONE, ERR: begin
        state_n   = IDLE;
        product_n = '0;
        cnt_n     = '0;
        stall_n   = '0;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    nib_valid_n = (state_n == SEND);
    nib_idx_n   = nib_valid_n ? phys_idx(cnt_n) : 2'd0;
    nib_out_n   = nib_valid_n ? product_n[{nib_idx_n, 2'b00} +: 4] : 4'd0;
    busy_n      = (state_n != IDLE);
    done_n      = (state_n == DONE);
    timeout_n   = (state_n == ERR);
  end

endmodule

// File: tb/tb_nibble_result_unloader.sv
// Bench for nibble_result_unloader.
// Three instances (LSB-first, MSB-first, short timeout) share one stimulus.
// Checks use a table of vectors, hand-written corner sequences, and random traffic.
module tb_nibble_result_unloader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start;
  logic       nib_ack;
  logic [7:0] in_a;
  logic [7:0] in_b;

  logic [2:0][3:0] nib_out_v;
  logic [2:0][1:0] nib_idx_v;
  logic [2:0]      nib_valid_v;
  logic [2:0]      busy_v;
  logic [2:0]      done_v;
  logic [2:0]      timeout_v;

  nibble_result_unloader #(.MSB_FIRST(0), .ACK_TIMEOUT(15)) u_lsb (
    .clk(clk), .rst_n(rst_n), .start(start), .in_a(in_a), .in_b(in_b),
    .nib_out(nib_out_v[0]), .nib_valid(nib_valid_v[0]), .nib_idx(nib_idx_v[0]),
    .nib_ack(nib_ack), .busy(busy_v[0]), .done(done_v[0]), .timeout(timeout_v[0]));

  nibble_result_unloader #(.MSB_FIRST(1), .ACK_TIMEOUT(15)) u_msb (
    .clk(clk), .rst_n(rst_n), .start(start), .in_a(in_a), .in_b(in_b),
    .nib_out(nib_out_v[1]), .nib_valid(nib_valid_v[1]), .nib_idx(nib_idx_v[1]),
    .nib_ack(nib_ack), .busy(busy_v[1]), .done(done_v[1]), .timeout(timeout_v[1]));

  nibble_result_unloader #(.MSB_FIRST(0), .ACK_TIMEOUT(4)) u_to4 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_a(in_a), .in_b(in_b),
    .nib_out(nib_out_v[2]), .nib_valid(nib_valid_v[2]), .nib_idx(nib_idx_v[2]),
    .nib_ack(nib_ack), .busy(busy_v[2]), .done(done_v[2]), .timeout(timeout_v[2]));

  localparam bit          MSBP [3] = '{1'b0, 1'b1, 1'b0};
  localparam int unsigned ATP  [3] = '{15, 15, 4};

  int checks = 0;
  int errors = 0;

  // Reference model: how many nibbles are still owed, the product, the
  // current run of unacknowledged cycles and any pending end-of-op pulse.
  int unsigned rem   [3];
  logic [15:0] prod  [3];
  int unsigned stall [3];
  bit          done_p[3];
  bit          to_p  [3];

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
    int          hold;
    bit          noise;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input int d, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[u%0d] at %0t: got %0h expected %0h", name, d, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      rem[d] = 0; prod[d] = '0; stall[d] = 0; done_p[d] = 1'b0; to_p[d] = 1'b0;
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    for (int d = 0; d < 3; d++) begin
      if (done_p[d] || to_p[d]) begin
        done_p[d] = 1'b0;
        to_p[d]   = 1'b0;
      end else if (rem[d] == 0) begin
        if (start) begin
          prod[d]  = 16'(in_a) * 16'(in_b);
          rem[d]   = 4;
          stall[d] = 0;
        end
      end else if (nib_ack) begin
        rem[d]   = rem[d] - 1;
        stall[d] = 0;
        if (rem[d] == 0) done_p[d] = 1'b1;
      end else begin
        stall[d] = stall[d] + 1;
        if (ATP[d] != 0 && stall[d] == ATP[d]) begin
          rem[d]  = 0;
          to_p[d] = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 3; d++) begin
      bit          ev;
      int unsigned sent;
      int unsigned idx;
      logic [3:0]  eo;
      ev   = (rem[d] != 0);
      sent = 4 - rem[d];
      idx  = ev ? (MSBP[d] ? 3 - sent : sent) : 0;
      eo   = ev ? 4'(prod[d] >> (4 * idx)) : 4'h0;
      chk("nib_valid", d, 16'(nib_valid_v[d]), 16'(ev));
      chk("nib_idx",   d, 16'(nib_idx_v[d]),   16'(idx));
      chk("nib_out",   d, 16'(nib_out_v[d]),   16'(eo));
      chk("busy",      d, 16'(busy_v[d]),      16'(ev || done_p[d] || to_p[d]));
      chk("done",      d, 16'(done_v[d]),      16'(done_p[d]));
      chk("timeout",   d, 16'(timeout_v[d]),   16'(to_p[d]));
    end
  endtask

  // One clock: model follows the edge, outputs are compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    compare_all();
  endtask

  // One full operation with fixed expectations from the table record.
  task automatic run_op(input vec_t v);
    logic [15:0] ep;
    int          hold;
    ep      = v.prod;
    in_a    = v.a;
    in_b    = v.b;
    start   = 1'b1;
    nib_ack = 1'b1;
    cycle();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      hold = (k == 1) ? v.hold : 0;
      for (int h = 0; h <= hold; h++) begin
        nib_ack = (h == hold);
        chk("tbl_nib_lsb", 0, 16'(nib_out_v[0]), 16'(ep[4*k +: 4]));
        chk("tbl_idx_lsb", 0, 16'(nib_idx_v[0]), 16'(k));
        chk("tbl_nib_msb", 1, 16'(nib_out_v[1]), 16'(ep[4*(3-k) +: 4]));
        chk("tbl_idx_msb", 1, 16'(nib_idx_v[1]), 16'(3 - k));
        chk("tbl_valid",   2, 16'(nib_valid_v[2]), 16'd1);
        start = v.noise && (k == 2) && (h == 0);
        if (start) in_a = 8'h77;
        cycle();
      end
    end
    start   = 1'b0;
    nib_ack = 1'b1;
    for (int d = 0; d < 3; d++) begin
      chk("tbl_done",      d, 16'(done_v[d]),      16'd1);
      chk("tbl_timeout",   d, 16'(timeout_v[d]),   16'd0);
      chk("tbl_valid_end", d, 16'(nib_valid_v[d]), 16'd0);
    end
    cycle();
    for (int d = 0; d < 3; d++) chk("tbl_idle", d, 16'(busy_v[d]), 16'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pct;

    tbl[0] = '{8'h12, 8'h34, 16'h03A8, 0, 1'b0};
    tbl[1] = '{8'hFF, 8'hFF, 16'hFE01, 0, 1'b0};
    tbl[2] = '{8'h12, 8'h34, 16'h03A8, 3, 1'b0};
    tbl[3] = '{8'h12, 8'h34, 16'h03A8, 0, 1'b1};
    tbl[4] = '{8'h03, 8'h05, 16'h000F, 0, 1'b0};
    tbl[5] = '{8'h00, 8'hAB, 16'h0000, 1, 1'b0};
    tbl[6] = '{8'hA5, 8'h3C, 16'h26AC, 2, 1'b0};
    tbl[7] = '{8'h7F, 8'h81, 16'h3FFF, 0, 1'b0};

    // Reset with start held high must leave everything idle.
    rst_n   = 1'b0;
    start   = 1'b1;
    nib_ack = 1'b1;
    in_a    = 8'h12;
    in_b    = 8'h34;
    model_reset();
    repeat (3) cycle();
    for (int d = 0; d < 3; d++) chk("reset_busy", d, 16'(busy_v[d]), 16'd0);
    rst_n = 1'b1;
    start = 1'b0;
    cycle();

    foreach (tbl[i]) run_op(tbl[i]);

    // Receiver never acknowledges: short-timeout instance aborts after 4 valid cycles.
    in_a    = 8'h12;
    in_b    = 8'h34;
    start   = 1'b1;
    nib_ack = 1'b0;
    cycle();
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("to_valid",   2, 16'(nib_valid_v[2]), 16'd1);
      chk("to_nopulse", 2, 16'(timeout_v[2]),   16'd0);
      cycle();
    end
    chk("to_pulse",   2, 16'(timeout_v[2]),   16'd1);
    chk("to_nodone",  2, 16'(done_v[2]),      16'd0);
    chk("to_invalid", 2, 16'(nib_valid_v[2]), 16'd0);
    cycle();
    chk("to_idle",     2, 16'(busy_v[2]),    16'd0);
    chk("to_oneshot",  2, 16'(timeout_v[2]), 16'd0);
    nib_ack = 1'b1;
    repeat (6) cycle();
    chk("to_others_idle", 0, 16'(busy_v[0]), 16'd0);
    chk("to_others_idle", 1, 16'(busy_v[1]), 16'd0);

    // Asynchronous reset after the second transfer.
    in_a    = 8'h12;
    in_b    = 8'h34;
    start   = 1'b1;
    nib_ack = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b0;
    start = 1'b1;
    #1;
    model_reset();
    compare_all();
    for (int d = 0; d < 3; d++) begin
      chk("rst_async_valid", d, 16'(nib_valid_v[d]), 16'd0);
      chk("rst_async_done",  d, 16'(done_v[d]),      16'd0);
    end
    cycle();
    rst_n = 1'b1;
    start = 1'b0;
    cycle();
    run_op(tbl[4]);

    // Random traffic against the model, with occasional resets.
    pct = 60;
    for (int i = 0; i < 3000; i++) begin
      if (i % 20 == 0) begin
        case ($urandom_range(0, 2))
          0:       pct = 20;
          1:       pct = 60;
          default: pct = 95;
        endcase
      end
      start   = ($urandom_range(0, 3) == 0);
      in_a    = 8'($urandom);
      in_b    = 8'($urandom);
      nib_ack = ($urandom_range(0, 99) < pct);
      if (i % 500 == 250) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        cycle();
        rst_n = 1'b1;
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
